// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forward selects, wait-FSM states, PC register index.
// Latency: n/a (types only). Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        ST_RUN,
        ST_WAIT
    } hz_state_t;

    localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One-operand bypass select: picks M-stage ALU result over W-stage result over regfile.
// Latency: combinational. Backpressure: none.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [3:0] ra_e,
    input  logic [3:0] wa3_m,
    input  logic [3:0] wa3_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    logic not_pc;

    // R15 reads come from the PC path, never from a bypass.
    assign not_pc = (ra_e != REG_PC);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (ra_e == wa3_m) && not_pc) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (ra_e == wa3_w) && not_pc) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush/forward control with bounded data-memory wait FSM; HAZARD_PERF_EN adds perf counters.
// Latency: stall/flush/forward are combinational, same cycle as the condition.
// Backpressure: a pending memory access freezes the whole pipe for at most MEM_TIMEOUT cycles.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  WA3M,
    input  logic [3:0]  WA3W,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        PCSrcD,
    input  logic        PCSrcE,
    input  logic        PCSrcM,
    input  logic        PCSrcW,
    input  logic        BranchTakenE,
    input  logic        mem_req_m,
    input  logic        mem_ready_m,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic [1:0] fwd_a, fwd_b;
    logic       ld_stall, pc_pend, mem_stall, at_limit;

    hazard_fwd_sel u_fwd_a (
        .ra_e        (RA1E),
        .wa3_m       (WA3M),
        .wa3_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .ra_e        (RA2E),
        .wa3_m       (WA3M),
        .wa3_w       (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b)
    );

    assign ld_stall  = MemtoRegE && RegWriteE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;
    assign at_limit  = (state_q == ST_WAIT) && (wait_cnt_q == TMO);
    assign mem_stall = mem_req_m && !mem_ready_m && !at_limit;

    // Reset forces a safe control word asynchronously, independent of the flops.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        if (rst_n) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = ld_stall | pc_pend;
                StallD = ld_stall;
                FlushE = ld_stall | BranchTakenE;
                FlushD = pc_pend | PCSrcW | BranchTakenE;
                FlushW = 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ready_m || !mem_req_m) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TMO) begin
                    // Forced release: the stall already dropped combinationally this cycle.
                    state_d       = ST_RUN;
                    wait_cnt_d    = '0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(StallF);
        perf_flush_d = perf_flush_q + 32'(FlushD | FlushE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MEM_TIMEOUT=8; expected control words are hand-computed.
module tb_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic        mem_req_m, mem_ready_m;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic        mem_timeout;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    logic [6:0]  ctl;
    int          checks;
    int          errors;
    logic [31:0] exp_perf_stall;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_unit #(.MEM_TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .RA1D           (RA1D),
        .RA2D           (RA2D),
        .RA1E           (RA1E),
        .RA2E           (RA2E),
        .WA3E           (WA3E),
        .WA3M           (WA3M),
        .WA3W           (WA3W),
        .RegWriteE      (RegWriteE),
        .RegWriteM      (RegWriteM),
        .RegWriteW      (RegWriteW),
        .MemtoRegE      (MemtoRegE),
        .PCSrcD         (PCSrcD),
        .PCSrcE         (PCSrcE),
        .PCSrcM         (PCSrcM),
        .PCSrcW         (PCSrcW),
        .BranchTakenE   (BranchTakenE),
        .mem_req_m      (mem_req_m),
        .mem_ready_m    (mem_ready_m),
        .ForwardAE      (ForwardAE),
        .ForwardBE      (ForwardBE),
        .StallF         (StallF),
        .StallD         (StallD),
        .StallE         (StallE),
        .StallM         (StallM),
        .FlushD         (FlushD),
        .FlushE         (FlushE),
        .FlushW         (FlushW),
        .mem_timeout    (mem_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
        mem_req_m = 1'b1;
        #3;
        checks++;
        if (ctl !== 7'b0000111) begin
            errors++; $display("FAIL reset_ctl got %b want %b", ctl, 7'b0000111);
        end
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL reset_fwd_a got %b want 00", ForwardAE);
        end
        checks++;
        if (mem_timeout !== 1'b0 || perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got tmo=%b stall=%0d flush=%0d want 0 0 0",
                     mem_timeout, perf_stall_cnt, perf_flush_cnt);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL idle_ctl got %b want 0000000", ctl);
        end
    endtask

    task automatic test_forward();
        next_cycle();
        clear_inputs();
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
        RA2E = 4'd4;
        #1;
        checks++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_m_wins got A=%b B=%b want A=10 B=00", ForwardAE, ForwardBE);
        end
        RegWriteM = 1'b0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_w got %b want 01", ForwardAE);
        end
        RA1E = 4'hF; WA3M = 4'hF; WA3W = 4'hF; RegWriteM = 1'b1;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_pc got %b want 00", ForwardAE);
        end
        RA1E = 4'd1; RA2E = 4'd7; WA3M = 4'd2; WA3W = 4'd7;
        #1;
        checks++;
        if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_b_w got A=%b B=%b want A=00 B=01", ForwardAE, ForwardBE);
        end
        WA3M = 4'd7;
        #1;
        checks++;
        if (ForwardBE !== 2'b10) begin
            errors++; $display("FAIL fwd_b_m got %b want 10", ForwardBE);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        #1;
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++; $display("FAIL ld_stall got %b want 1100010", ctl);
        end
        // Bubble now sits in E; D instruction was held.
        next_cycle();
        MemtoRegE = 1'b0; RegWriteE = 1'b0; WA3E = 4'd0;
        #1;
        checks++;
        if (ctl !== 7'b0000000) begin
            errors++; $display("FAIL ld_release got %b want 0000000", ctl);
        end
    endtask

    task automatic test_pc_flush();
        int stall_cycles;
        int flush_cycles;
        stall_cycles = 0;
        flush_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            clear_inputs();
            PCSrcD = (i == 0);
            PCSrcE = (i == 1);
            PCSrcM = (i == 2);
            PCSrcW = (i == 3);
            #1;
            if (StallF === 1'b1) stall_cycles++;
            if (FlushD === 1'b1) flush_cycles++;
        end
        checks++;
        if (stall_cycles != 3) begin
            errors++; $display("FAIL pc_stallf_cycles got %0d want 3", stall_cycles);
        end
        checks++;
        if (flush_cycles != 4) begin
            errors++; $display("FAIL pc_flushd_cycles got %0d want 4", flush_cycles);
        end
    endtask

    task automatic test_branch_ld();
        next_cycle();
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd6; RA1D = 4'd6; BranchTakenE = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b1100110) begin
            errors++; $display("FAIL branch_ld got %b want 1100110", ctl);
        end
    endtask

    task automatic test_timeout();
        next_cycle();
        clear_inputs();
        mem_req_m = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (i < 8 && (ctl !== 7'b1111001 || mem_timeout !== 1'b0)) begin
                errors++; $display("FAIL tmo_stall_%0d got ctl=%b tmo=%b want 1111001 0", i, ctl, mem_timeout);
            end else if (i == 8 && ctl !== 7'b0000000) begin
                errors++; $display("FAIL tmo_release got %b want 0000000", ctl);
            end
            next_cycle();
        end
        mem_req_m = 1'b0;
        #1;
        checks++;
        if (mem_timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_set got %b want 1", mem_timeout);
        end
        next_cycle();
        next_cycle();
        checks++;
        if (mem_timeout !== 1'b1 || ctl !== 7'b0000000) begin
            errors++; $display("FAIL tmo_sticky got tmo=%b ctl=%b want 1 0000000", mem_timeout, ctl);
        end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        clear_inputs();
        mem_req_m = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (ctl !== 7'b1111001) begin
            errors++; $display("FAIL rw_in_wait got %b want 1111001", ctl);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0000111 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL rw_reset got ctl=%b tmo=%b want 0000111 0", ctl, mem_timeout);
        end
        checks++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            errors++; $display("FAIL rw_perf got %0d %0d want 0 0", perf_stall_cnt, perf_flush_cnt);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_mem_wait3();
        int stall_cycles;
        stall_cycles = 0;
        next_cycle();
        clear_inputs();
        mem_req_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready_m = (i == 3);
            BranchTakenE = (i < 3);
            #1;
            if (ctl === 7'b1111001) stall_cycles++;
            next_cycle();
        end
        clear_inputs();
        #1;
        checks++;
        if (stall_cycles != 3) begin
            errors++; $display("FAIL wait3_cycles got %0d want 3", stall_cycles);
        end
        checks++;
        if (mem_timeout !== 1'b0 || ctl !== 7'b0000000) begin
            errors++; $display("FAIL wait3_end got tmo=%b ctl=%b want 0 0000000", mem_timeout, ctl);
        end
`ifdef HAZARD_PERF_EN
        exp_perf_stall = 32'd3;
`else
        exp_perf_stall = 32'd0;
`endif
        checks++;
        if (perf_stall_cnt !== exp_perf_stall || perf_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL wait3_perf got stall=%0d flush=%0d want %0d 0",
                     perf_stall_cnt, perf_flush_cnt, exp_perf_stall);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_pc_flush();
        test_branch_ld();
        test_timeout();
        test_reset_mid_wait();
        test_mem_wait3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
